// File: rtl/v_counter_sync_if.sv
// Signal bundle between the horizontal counter stage and the vertical timing stage.
interface v_counter_sync_if;
  logic [9:0]  hcount;
  logic        trig_V;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        frame_tick;
  logic [1:0]  v_state;
  logic [15:0] frame_count;

  modport master (
    output hcount, trig_V,
    input  vcount, hsync, vsync, video_on, pixel_x, pixel_y,
    input  frame_tick, v_state, frame_count
  );

  modport slave (
    input  hcount, trig_V,
    output vcount, hsync, vsync, video_on, pixel_x, pixel_y,
    output frame_tick, v_state, frame_count
  );
endinterface

// File: rtl/v_counter_sync.sv
// Vertical stage of the 640x480@60 VGA timing chain: line counter, vertical-region FSM and registered decode.
// Optional feature: define FRAME_COUNT_EN to build the 16-bit frame counter (otherwise frame_count is 0).
module v_counter_sync #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    v_counter_sync_if.slave   bus
);

    localparam logic [9:0] L_H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] L_HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] L_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] L_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] L_V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] L_VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] L_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] L_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_FP     = 2'd1,
        S_SYNC   = 2'd2,
        S_BP     = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_vcount;
    logic [9:0] w_vcount_nxt;
    logic       w_wrap;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic [9:0] r_pixel_x;
    logic [9:0] r_pixel_y;
    logic       r_frame_tick;

    logic       w_h_in_range;
    logic       w_h_sync_zone;
    logic       w_visible;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vcount <= '0;
            r_state  <= S_ACTIVE;
        end else begin
            r_vcount <= w_vcount_nxt;
            r_state  <= w_state_nxt;
        end
    end

    // Region transitions look at the incoming line so state and vcount change on the same edge.
    always_comb begin
        w_vcount_nxt = r_vcount;
        w_state_nxt  = r_state;
        w_wrap       = 1'b0;
        if (bus.trig_V) begin
            if (r_vcount == L_V_LAST) begin
                w_vcount_nxt = '0;
                w_wrap       = 1'b1;
            end else begin
                w_vcount_nxt = r_vcount + 10'd1;
            end
            case (r_state)
                S_ACTIVE: if (w_vcount_nxt == L_V_ACT)    w_state_nxt = S_FP;
                S_FP:     if (w_vcount_nxt == L_VS_START) w_state_nxt = S_SYNC;
                S_SYNC:   if (w_vcount_nxt == L_VS_END)   w_state_nxt = S_BP;
                S_BP:     if (w_wrap)                     w_state_nxt = S_ACTIVE;
                default:                                  w_state_nxt = S_ACTIVE;
            endcase
        end
    end

    assign w_h_in_range  = (bus.hcount <= L_H_LAST);
    assign w_h_sync_zone = w_h_in_range && (bus.hcount >= L_HS_START) && (bus.hcount <= L_HS_END);
    assign w_visible     = (bus.hcount < L_H_ACT) && (r_state == S_ACTIVE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_video_on   <= 1'b0;
            r_pixel_x    <= '0;
            r_pixel_y    <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_hsync      <= w_h_sync_zone ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= (r_state == S_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_video_on   <= w_visible;
            r_pixel_x    <= w_visible ? bus.hcount : '0;
            r_pixel_y    <= w_visible ? r_vcount : '0;
            r_frame_tick <= w_wrap;
        end
    end

`ifdef FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (w_wrap) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign bus.frame_count = r_frame_count;
`else
    assign bus.frame_count = '0;
`endif

    assign bus.vcount     = r_vcount;
    assign bus.v_state    = r_state;
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.video_on   = r_video_on;
    assign bus.pixel_x    = r_pixel_x;
    assign bus.pixel_y    = r_pixel_y;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_v_counter_sync.sv
// Self-checking bench for v_counter_sync against a line/frame arithmetic model (honours FRAME_COUNT_EN).
module tb_v_counter_sync;
    localparam bit POL = 1'b0;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    v_counter_sync_if bus ();

    v_counter_sync #(.SYNC_POL(POL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: the line number and frame total, plus the expected registered decode.
    int         m_line;
    int         m_frames;
    logic       e_hsync, e_vsync, e_von, e_tick;
    logic [9:0] e_px, e_py;

    function automatic int region(input int l);
        if (l < 480) return 0;
        if (l < 490) return 1;
        if (l < 492) return 2;
        return 3;
    endfunction

    function automatic logic [15:0] exp_fc();
`ifdef FRAME_COUNT_EN
        return 16'(m_frames);
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_reset();
        m_line   = 0;
        m_frames = 0;
        e_hsync  = ~POL;
        e_vsync  = ~POL;
        e_von    = 1'b0;
        e_tick   = 1'b0;
        e_px     = '0;
        e_py     = '0;
    endtask

    // Starts and ends on a falling edge; one rising edge in between.
    task automatic drive_cycle(input logic [9:0] h, input logic t);
        bus.hcount = h;
        bus.trig_V = t;
        @(posedge clock);
        e_hsync = (h >= 10'd656 && h <= 10'd751) ? POL : ~POL;
        e_vsync = (region(m_line) == 2) ? POL : ~POL;
        e_von   = (h < 10'd640) && (m_line < 480);
        e_px    = e_von ? h : 10'd0;
        e_py    = e_von ? 10'(m_line) : 10'd0;
        e_tick  = t && (m_line == 524);
        if (t) begin
            if (m_line == 524) m_frames = (m_frames + 1) % 65536;
            m_line = (m_line + 1) % 525;
        end
        @(negedge clock);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) drive_cycle(10'd0, 1'b1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.trig_V = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        bus.hcount = 10'd100;
        for (int i = 0; i < 4; i++) begin
            bus.trig_V = ~bus.trig_V;
            @(negedge clock);
            checks++;
            if ({bus.vcount, bus.v_state, bus.video_on, bus.pixel_x, bus.pixel_y, bus.frame_tick}
                !== 34'd0) begin
                failures++;
                $display("FAIL reset_zero vcount=%0d v_state=%0d von=%b px=%0d py=%0d tick=%b required all 0",
                         bus.vcount, bus.v_state, bus.video_on, bus.pixel_x, bus.pixel_y, bus.frame_tick);
            end
            checks++;
            if ({bus.hsync, bus.vsync} !== 2'b11 || bus.frame_count !== 16'd0) begin
                failures++;
                $display("FAIL reset_sync hsync=%b vsync=%b frame_count=%0d required 1 1 0",
                         bus.hsync, bus.vsync, bus.frame_count);
            end
        end
        bus.trig_V = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_line_step();
        drive_cycle(10'd0, 1'b1);
        checks++;
        if (bus.vcount !== 10'd1) begin
            failures++;
            $display("FAIL line_step vcount=%0d required 1", bus.vcount);
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(10'($urandom_range(0, 799)), 1'b0);
            checks++;
            if (bus.vcount !== 10'd1) begin
                failures++;
                $display("FAIL line_hold vcount=%0d required 1", bus.vcount);
            end
        end
    endtask

    task automatic test_vsync_window();
        do_reset();
        pulses(490);
        checks++;
        if (bus.v_state !== 2'd2 || bus.vcount !== 10'd490 || bus.vsync !== 1'b1) begin
            failures++;
            $display("FAIL vsync_enter v_state=%0d vcount=%0d vsync=%b required 2 490 1",
                     bus.v_state, bus.vcount, bus.vsync);
        end
        drive_cycle(10'd700, 1'b0);
        checks++;
        if (bus.vsync !== 1'b0) begin
            failures++;
            $display("FAIL vsync_active vsync=%b required 0", bus.vsync);
        end
        pulses(2);
        drive_cycle(10'd0, 1'b0);
        checks++;
        if (bus.vsync !== 1'b1 || bus.v_state !== 2'd3 || bus.vcount !== 10'd492) begin
            failures++;
            $display("FAIL vsync_exit vsync=%b v_state=%0d vcount=%0d required 1 3 492",
                     bus.vsync, bus.v_state, bus.vcount);
        end
    endtask

    task automatic test_frame_wrap();
        pulses(32);
        checks++;
        if (bus.vcount !== 10'd524 || bus.frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL pre_wrap vcount=%0d tick=%b required 524 0", bus.vcount, bus.frame_tick);
        end
        drive_cycle(10'd0, 1'b1);
        checks++;
        if (bus.vcount !== 10'd0 || bus.frame_tick !== 1'b1 || bus.v_state !== 2'd0
            || bus.frame_count !== exp_fc()) begin
            failures++;
            $display("FAIL wrap vcount=%0d tick=%b v_state=%0d fc=%0d required 0 1 0 %0d",
                     bus.vcount, bus.frame_tick, bus.v_state, bus.frame_count, exp_fc());
        end
        drive_cycle(10'd0, 1'b0);
        checks++;
        if (bus.frame_tick !== 1'b0 || bus.vcount !== 10'd0) begin
            failures++;
            $display("FAIL tick_width tick=%b vcount=%0d required 0 0", bus.frame_tick, bus.vcount);
        end
    endtask

    task automatic test_visible();
        do_reset();
        pulses(479);
        drive_cycle(10'd639, 1'b0);
        checks++;
        if (bus.video_on !== 1'b1 || bus.pixel_x !== 10'd639 || bus.pixel_y !== 10'd479) begin
            failures++;
            $display("FAIL vis_last von=%b px=%0d py=%0d required 1 639 479",
                     bus.video_on, bus.pixel_x, bus.pixel_y);
        end
        drive_cycle(10'd640, 1'b0);
        checks++;
        if (bus.video_on !== 1'b0 || bus.pixel_x !== 10'd0 || bus.pixel_y !== 10'd0) begin
            failures++;
            $display("FAIL vis_edge von=%b px=%0d py=%0d required 0 0 0",
                     bus.video_on, bus.pixel_x, bus.pixel_y);
        end
        drive_cycle(10'd655, 1'b0);
        checks++;
        if (bus.hsync !== 1'b1) begin
            failures++;
            $display("FAIL hsync_before hsync=%b required 1", bus.hsync);
        end
        drive_cycle(10'd656, 1'b0);
        checks++;
        if (bus.hsync !== 1'b0) begin
            failures++;
            $display("FAIL hsync_start hsync=%b required 0", bus.hsync);
        end
        drive_cycle(10'd751, 1'b0);
        drive_cycle(10'd752, 1'b0);
        checks++;
        if (bus.hsync !== 1'b1) begin
            failures++;
            $display("FAIL hsync_end hsync=%b required 1", bus.hsync);
        end
        drive_cycle(10'd900, 1'b0);
        checks++;
        if (bus.hsync !== 1'b1 || bus.video_on !== 1'b0) begin
            failures++;
            $display("FAIL h_out_of_range hsync=%b von=%b required 1 0", bus.hsync, bus.video_on);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        pulses(300);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.vcount !== 10'd0 || bus.v_state !== 2'd0) begin
            failures++;
            $display("FAIL midreset_async vcount=%0d v_state=%0d required 0 0", bus.vcount, bus.v_state);
        end
        for (int i = 0; i < 3; i++) begin
            bus.trig_V = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (bus.vcount !== 10'd0) begin
            failures++;
            $display("FAIL midreset_hold vcount=%0d required 0", bus.vcount);
        end
        bus.trig_V = 1'b0;
        reset_n = 1'b1;
        pulses(5);
        checks++;
        if (bus.vcount !== 10'd5) begin
            failures++;
            $display("FAIL midreset_resume vcount=%0d required 5", bus.vcount);
        end
    endtask

    task automatic test_random();
        logic [51:0] got, exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
            got = {bus.vcount, bus.v_state, bus.hsync, bus.vsync, bus.video_on,
                   bus.pixel_x, bus.pixel_y, bus.frame_tick, bus.frame_count};
            exp = {10'(m_line), 2'(region(m_line)), e_hsync, e_vsync, e_von,
                   e_px, e_py, e_tick, exp_fc()};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random cycle=%0d got=%h required=%h (vcount,v_state,hs,vs,von,px,py,tick,fc)",
                         i, got, exp);
            end
        end
    endtask

    initial begin
        bus.hcount = '0;
        bus.trig_V = 1'b0;
        @(negedge clock);
        test_reset();
        test_line_step();
        test_vsync_window();
        test_frame_wrap();
        test_visible();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
